// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction RAM; loads a program over a
// valid/ready stream, holds the CPU in reset, then serves fetches.
//
// Ports:
//   CK        clock, all state updates on posedge
//   RST       synchronous active-high reset
//   LD_VALID  load word present on LD_DATA
//   LD_READY  registered; high only while loading
//   LD_DATA   program word
//   LD_LAST   marks the final word of the stream
//   IA        CPU instruction address
//   ID        instruction word, combinational from IA
//   CPU_RST   holds the CPU in reset until the program is loaded
//   DONE      high once the program is loaded (RUN)
//   ERR       high on a failed load (FAULT)
//
// Build option: define IMEM_CKSUM_EN to treat the LAST word as a
// 16-bit checksum of the stored words instead of a program word.

module imem_loader #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          LD_VALID,
    output logic          LD_READY,
    input  logic [DW-1:0] LD_DATA,
    input  logic          LD_LAST,
    input  logic [15:0]   IA,
    output logic [DW-1:0] ID,
    output logic          CPU_RST,
    output logic          DONE,
    output logic          ERR
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [AW-1:0] WMAX = '1;

    logic [DW-1:0] mem [2**AW];

    state_t        state;
    logic [AW-1:0] waddr;
    logic [AW:0]   count;
    logic          acc;
    logic          store;
    logic          in_range;

    // LD_READY is only high in LOAD, so it doubles as the state qualifier
    assign acc = LD_VALID & LD_READY;

`ifdef IMEM_CKSUM_EN
    logic [DW-1:0] sum;

    // The LAST word carries the checksum and never lands in RAM
    assign store = acc & ~LD_LAST;
`else
    assign store = acc;
`endif

    // RAM has no reset: contents survive RST and are masked by count
    always_ff @(posedge CK) begin
        if (store) begin
            mem[waddr] <= LD_DATA;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state    <= S_LOAD;
            waddr    <= '0;
            count    <= '0;
            LD_READY <= 1'b1;
            CPU_RST  <= 1'b1;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
`ifdef IMEM_CKSUM_EN
            sum      <= '0;
`endif
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (acc) begin
`ifdef IMEM_CKSUM_EN
                        if (LD_LAST) begin
                            LD_READY <= 1'b0;
                            if (sum == LD_DATA) begin
                                state   <= S_RUN;
                                CPU_RST <= 1'b0;
                                DONE    <= 1'b1;
                            end else begin
                                state <= S_FAULT;
                                ERR   <= 1'b1;
                            end
                        end else begin
                            waddr <= waddr + 1'b1;
                            count <= count + 1'b1;
                            sum   <= sum + LD_DATA;
                            // RAM full and still no LAST: overflow
                            if (waddr == WMAX) begin
                                state    <= S_FAULT;
                                LD_READY <= 1'b0;
                                ERR      <= 1'b1;
                            end
                        end
`else
                        waddr <= waddr + 1'b1;
                        count <= count + 1'b1;
                        if (LD_LAST) begin
                            state    <= S_RUN;
                            LD_READY <= 1'b0;
                            CPU_RST  <= 1'b0;
                            DONE     <= 1'b1;
                        end else if (waddr == WMAX) begin
                            // Last RAM slot filled without LAST
                            state    <= S_FAULT;
                            LD_READY <= 1'b0;
                            ERR      <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state    <= S_FAULT;
                    LD_READY <= 1'b0;
                    CPU_RST  <= 1'b1;
                    DONE     <= 1'b0;
                    ERR      <= 1'b1;
                end
            endcase
        end
    end

    // Addresses beyond the RAM or beyond the loaded image read as zero
    assign in_range = ((IA >> AW) == 16'd0) &&
                      ({1'b0, IA[AW-1:0]} < count);

    assign ID = in_range ? mem[IA[AW-1:0]] : '0;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time instruction memory for the 16-bit CPU, sitting directly upstream of the CPU's instruction port (IA/ID).
- After reset it accepts a program as a stream of 16-bit words over a valid/ready handshake and writes them into an internal word RAM.
- It holds the CPU in reset while loading. Once the last word is accepted, it releases the CPU and serves instruction fetches asynchronously.

Parameters:
AW, 8, word-address width; RAM depth = 2**AW words.
DW, 16, data/instruction width; fixed at 16 for the current CPU.

Ports:
CK  input  1  clock, all state on posedge
RST  input  1  reset; synchronous, active-high
LD_VALID  input  1  load word present on LD_DATA
LD_READY  output  1  loader accepts a word this cycle
LD_DATA  input  16  program word
LD_LAST  input  1  qualifies final word of the stream
IA  input  16  CPU instruction address
ID  output  16  instruction word to CPU, combinational from IA
CPU_RST  output  1  drives CPU RST; high until program loaded
DONE  output  1  high in RUN state
ERR  output  1  high in FAULT state

Behaviour:
- States: LOAD, RUN, FAULT. The state and all registers are updated only on posedge CK.
- Reset (RST=1 at a clock edge):
  - state<=LOAD, waddr<=0, count<=0
  - CPU_RST=1, LD_READY=1, DONE=0, ERR=0
  - RAM contents are not cleared.
- Reset mid-load or in RUN/FAULT: same as above; the load restarts at address 0.
- Handshake: a word is accepted on the edge where LD_VALID=1 and LD_READY=1. LD_READY is a registered output and is high only in LOAD.
- LOAD, on an accepted word:
  - mem[waddr]<=LD_DATA, waddr<=waddr+1, count<=count+1
  - LD_LAST=1 -> state<=RUN.
  - LD_LAST=0 and waddr==2**AW-1 -> state<=FAULT (overflow). That word is still written.
  - LD_LAST=1 at waddr==2**AW-1 is legal -> RUN.
- LOAD with no accepted word: hold all state. Gaps in LD_VALID are allowed.
- RUN:
  - CPU_RST=0, DONE=1, LD_READY=0.
  - LD_VALID and LD_DATA are ignored.
  - State persists until RST.
- FAULT:
  - CPU_RST=1, ERR=1, LD_READY=0.
  - Sticky until RST.
- Latency: CPU_RST falls, and DONE rises, on the edge that accepts the LAST word. Both are visible in the following cycle.
- Read path: ID is a combinational function of IA (the CPU latches ID one edge after presenting IA).
  - ID = mem[IA[AW-1:0]] if IA[15:AW]==0 and IA[AW-1:0] < count.
  - Otherwise ID = 16'h0000. Unloaded or out-of-range addresses read as 0.
- count width is AW+1 so that a full RAM (count = 2**AW) is representable.
- A read and a write in the same cycle cannot occur, because the CPU is held in reset during LOAD.

Optional Feature:
Macro IMEM_CKSUM_EN.
- Defined:
  - The LAST-qualified word is a checksum and is not stored; waddr and count are not incremented for it.
  - The loader keeps a running 16-bit sum (mod 2**16) of all stored words; the sum is cleared on reset.
  - On LAST: sum==LD_DATA -> RUN; mismatch -> FAULT.
  - A LAST word arriving with zero stored words compares against sum 0.
- Undefined: the LAST word is an ordinary program word as described above, and no sum logic is built.

Test Plan:
1. RST, then stream 16'hC105, 16'hC203, 16'h0312 (LAST on the third), macro off -> CPU_RST=0 and DONE=1 the cycle after the third accept. IA=0,1,2 give ID=C105, C203, 0312. IA=3 and IA=16'h0100 give ID=0000.
2. Same stream with LD_VALID gaps of 0–3 idle cycles between words -> identical RAM contents. CPU_RST stays 1 until LAST is accepted.
3. AW=2, four words 16'h1111…16'h4444, none with LAST -> ERR=1, LD_READY=0 and CPU_RST=1 after the fourth accept. A fifth LD_VALID is not accepted.
4. After 2 words, assert RST for one cycle, then load 16'hAAAA with LAST -> DONE=1, ID(IA=0)=AAAA, ID(IA=1)=0000 (count=1).
5. In RUN, drive LD_VALID=1 with LD_DATA=16'hFFFF for 5 cycles -> LD_READY=0 and ID(IA=0) unchanged.
6. IMEM_CKSUM_EN: words 16'h0001, 16'h0002, then LAST 16'h0003 -> RUN with count=2. Repeat with LAST 16'h0004 -> FAULT, ERR=1.
